// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   localparam logic M0        = 1'b0;
   localparam logic M1        = 1'b1;
   localparam int   ARB_CNT_W = 32;

   // Ownership state that corresponds to a master index.
   function automatic arb_state_t own_state(input logic idx);
      return idx ? ARB_OWN1 : ARB_OWN0;
   endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational master selection: round-robin on contention from idle,
// burst-bounded ownership while one master keeps winning.
module mem_arb_sel
   import mem_arb_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int BCNT_W    = 4
) (
   input  logic [1:0]        req,
   input  arb_state_t        state,
   input  logic [BCNT_W-1:0] burst_cnt,
   input  logic              rr_last,
   output logic              sel_valid,
   output logic              sel_idx
);

   logic owner_idx;
   logic burst_left;

   // Pick a master from the request pair and the current ownership.
   always_comb begin
      sel_valid  = 1'b0;
      sel_idx    = M0;
      owner_idx  = (state == ARB_OWN1);
      burst_left = (int'(burst_cnt) < MAX_BURST);
      case (req)
         2'b01: begin
            sel_valid = 1'b1;
            sel_idx   = M0;
         end
         2'b10: begin
            sel_valid = 1'b1;
            sel_idx   = M1;
         end
         2'b11: begin
            sel_valid = 1'b1;
            if (state == ARB_IDLE)
               sel_idx = ~rr_last;
            else
               sel_idx = burst_left ? owner_idx : ~owner_idx;
         end
         default: begin
            sel_valid = 1'b0;
            sel_idx   = M0;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of one RAM port: zero-latency grant, payload
// mux to the RAM, registered read data one cycle after acceptance.
// Optional per-master stall counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AWIDTH    = 14,
   parameter int DWIDTH    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [DWIDTH/8-1:0]   m0_wbe,
   input  logic [AWIDTH-1:0]     m0_addr,
   input  logic [DWIDTH-1:0]     m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DWIDTH-1:0]     m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [DWIDTH/8-1:0]   m1_wbe,
   input  logic [AWIDTH-1:0]     m1_addr,
   input  logic [DWIDTH-1:0]     m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DWIDTH-1:0]     m1_rdata,
   output logic [AWIDTH-1:0]     mem_addr,
   output logic [DWIDTH-1:0]     mem_d,
   output logic                  mem_wen,
   output logic [DWIDTH/8-1:0]   mem_wbe,
   input  logic [DWIDTH-1:0]     mem_q
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [ARB_CNT_W-1:0]  m0_wait_cnt,
   output logic [ARB_CNT_W-1:0]  m1_wait_cnt
`endif
);

   localparam int BCNT_W = $clog2(MAX_BURST + 1);

   arb_state_t        state_reg, state_next;
   logic [BCNT_W-1:0] burst_cnt_reg, burst_cnt_next;
   logic              rr_last_reg, rr_last_next;

   logic [1:0] req_vec;
   logic [1:0] we_vec;
   logic       sel_raw_valid;
   logic       sel_valid;
   logic       sel_idx;

   assign req_vec = {m1_req, m0_req};
   assign we_vec  = {m1_we, m0_we};

   mem_arb_sel #(
      .MAX_BURST (MAX_BURST),
      .BCNT_W    (BCNT_W)
   ) u_sel (
      .req       (req_vec),
      .state     (state_reg),
      .burst_cnt (burst_cnt_reg),
      .rr_last   (rr_last_reg),
      .sel_valid (sel_raw_valid),
      .sel_idx   (sel_idx)
   );

   // Reset suppresses any grant so no write can reach the RAM that cycle.
   assign sel_valid = sel_raw_valid && !rst;
   assign m0_gnt    = sel_valid && (sel_idx == M0);
   assign m1_gnt    = sel_valid && (sel_idx == M1);

   // Route the selected master's payload to the RAM, all-zero when idle.
   always_comb begin
      mem_addr = '0;
      mem_d    = '0;
      mem_wbe  = '0;
      mem_wen  = 1'b0;
      if (sel_valid) begin
         mem_addr = sel_idx ? m1_addr  : m0_addr;
         mem_d    = sel_idx ? m1_wdata : m0_wdata;
         mem_wbe  = sel_idx ? m1_wbe   : m0_wbe;
         mem_wen  = sel_idx ? m1_we    : m0_we;
      end
   end

   // Ownership, saturating burst length and last-served master for next edge.
   always_comb begin
      state_next     = ARB_IDLE;
      burst_cnt_next = '0;
      rr_last_next   = rr_last_reg;
      if (sel_valid) begin
         state_next   = own_state(sel_idx);
         rr_last_next = sel_idx;
         if (state_reg == own_state(sel_idx))
            burst_cnt_next = (int'(burst_cnt_reg) < MAX_BURST) ?
                             burst_cnt_reg + 1'b1 : burst_cnt_reg;
         else
            burst_cnt_next = BCNT_W'(1);
      end
   end

   // Arbitration state register; m1 counts as last served so m0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ARB_IDLE;
         burst_cnt_reg <= '0;
         rr_last_reg   <= M1;
      end else begin
         state_reg     <= state_next;
         burst_cnt_reg <= burst_cnt_next;
         rr_last_reg   <= rr_last_next;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic              accept_rd;
         logic              rvalid_reg;
         logic [DWIDTH-1:0] rdata_reg;

         assign accept_rd = sel_valid && (sel_idx == 1'(gi)) && !we_vec[gi];

         // Capture RAM output on an accepted read; data holds until the next one.
         always_ff @(posedge clk) begin
            if (rst) begin
               rvalid_reg <= 1'b0;
               rdata_reg  <= '0;
            end else begin
               rvalid_reg <= accept_rd;
               if (accept_rd)
                  rdata_reg <= mem_q;
            end
         end
      end
   endgenerate

   assign m0_rvalid = g_rd[0].rvalid_reg;
   assign m0_rdata  = g_rd[0].rdata_reg;
   assign m1_rvalid = g_rd[1].rvalid_reg;
   assign m1_rdata  = g_rd[1].rdata_reg;

`ifdef ARB_PERF_CNT_EN
   logic [1:0] gnt_vec;
   assign gnt_vec = {m1_gnt, m0_gnt};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_wait
         logic [ARB_CNT_W-1:0] wait_cnt_reg;

         // Count cycles a master requests without being granted, saturating.
         always_ff @(posedge clk) begin
            if (rst)
               wait_cnt_reg <= '0;
            else if (req_vec[gi] && !gnt_vec[gi] && (wait_cnt_reg != '1))
               wait_cnt_reg <= wait_cnt_reg + 1'b1;
         end
      end
   endgenerate

   assign m0_wait_cnt = g_wait[0].wait_cnt_reg;
   assign m1_wait_cnt = g_wait[1].wait_cnt_reg;
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares one port of the dual-port, asynchronous-read, byte-enable-write data RAM, for example between the CPU load/store unit and a debug/DMA loader. It uses round-robin arbitration with bounded bursts, so neither master can starve the other. It makes a combinational grant decision with zero-bubble switching, and returns registered read data one cycle after the grant. It sits directly in front of the RAM port; the other RAM port is unaffected.

## Interface
- AWIDTH, 14, word address width (matches RAM)
- DWIDTH, 32, data width; byte lanes = DWIDTH/8
- MAX_BURST, 8, max consecutive grants to one master while the other waits (≥1)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- mN_req  in  1  master N (N=0,1) request; held with payload stable until granted
- mN_we  in  1  1 = write, 0 = read
- mN_wbe  in  DWIDTH/8  write byte enables
- mN_addr  in  AWIDTH  word address
- mN_wdata  in  DWIDTH  write data
- mN_gnt  out  1  combinational; req&&gnt at a rising edge = transaction accepted
- mN_rvalid  out  1  one-cycle pulse, cycle after an accepted read
- mN_rdata  out  DWIDTH  read data, valid while mN_rvalid
- mem_addr  out  AWIDTH  to RAM addr
- mem_d  out  DWIDTH  to RAM d
- mem_wen  out  1  to RAM wen
- mem_wbe  out  DWIDTH/8  to RAM wbe
- mem_q  in  DWIDTH  from RAM q (async read)
- mN_wait_cnt  out  32  stall counter, only with ARB_PERF_CNT_EN

## Operation
- State: IDLE (no owner), OWN0, OWN1; plus burst_cnt (0..MAX_BURST) and rr_last (last served master).
- Selection each cycle (combinational; rst forces none):
  - Only one master requesting: that master is selected.
  - Both requesting, state IDLE: select the master ≠ rr_last.
  - Both requesting, state OWNx: keep x if burst_cnt < MAX_BURST, else select the other.
  - None requesting: none selected.
- Grant: mN_gnt = selected==N. The RAM port is driven from the selected master's addr/wdata/wbe. mem_wen = selected master's we. With no selection: mem_addr=0, mem_d=0, mem_wbe=0, mem_wen=0.
- Next state on each edge:
  - Selected x: state=OWNx, rr_last=x. burst_cnt = burst_cnt+1 if x was already owner, else 1.
  - None selected: state=IDLE, burst_cnt=0. rr_last is held.
- Reads: on an accepted read, mem_q is captured into a per-master rdata register, and mN_rvalid=1 the next cycle. rdata holds its value until the next read of that master.
- Writes: performed by the RAM on the accepting edge. No response pulse is produced.
- Owner drops req: ownership is released the same cycle. An idle owner gives no priority.

## Timing
- Grant latency: 0 cycles; gnt is valid in the same cycle as req.
- Read latency: rvalid/rdata 1 cycle after the accepting edge. Back-to-back reads give rvalid high on consecutive cycles.
- Switching between masters adds no bubble cycle.
- Write-then-read to the same address by either master returns the new data (write at edge N, read sampled after N).
- Reset values: state=IDLE, rr_last=1 (so m0 wins the first contention), burst_cnt=0, mN_gnt=0, mN_rvalid=0, mN_rdata=0, mem_wen=0, mem_wbe=0, mem_addr=0, mem_d=0, wait counters=0.
- rst asserted mid-burst: gnt and mem_wen are forced 0 in that cycle, so no write occurs. A pending rvalid is cleared at that edge.
- MAX_BURST=1: strict alternation under continuous contention.
- burst_cnt saturates at MAX_BURST and never wraps.

## Configuration
- ARB_PERF_CNT_EN defined:
  - mN_wait_cnt increments on every cycle with mN_req=1 and mN_gnt=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_OWN0, ARB_OWN1).
  - Master index constants M0=0, M1=1.
  - Counter width constant ARB_CNT_W=32.
- Sub-module mem_arb_sel: the combinational selection function (reqs, state, burst_cnt, rr_last → sel_valid, sel_idx). It is unit-testable in isolation.
- Top level holds the state registers, the payload mux to the RAM, the rdata/rvalid registers and the optional counters.

## Test plan
- Single master: m0 writes 32'hDEADBEEF, wbe=4'hF, addr 5, then reads addr 5 → m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=32'hDEADBEEF. m1 sees no activity.
- First contention after reset: both masters read at once → m0 granted first, m1 granted next cycle with no bubble. rvalid pulses on consecutive cycles.
- Continuous contention, MAX_BURST=8, m0 already owner: m0 gets exactly 8 consecutive grants, then m1 is granted. With MAX_BURST=1 the grants alternate m0,m1,m0,m1.
- Byte enables: write 32'h11223344 to addr 3, then m1 writes 32'hAABBCCDD with wbe=4'b0101 → read returns 32'h11BB33DD.
- Reset mid-burst: assert rst for 1 cycle with m1 writing → no gnt, mem_wen=0, memory unchanged; next arbitration starts with m0 priority.
- ARB_PERF_CNT_EN: m1 stalled 5 cycles behind an m0 burst → m1_wait_cnt=5, m0_wait_cnt=0. Without the macro, the bench builds with the counters absent.
